// File: rtl/simmem_pkg.sv
// Shared types, constants and cost helpers for the simulated memory controller.
// Used by the read-path delay stage and its future write-path sibling.
package simmem_pkg;

  localparam int AxAddrWidth  = 20;
  localparam int AxIdWidth    = 4;
  localparam int AxLenWidth   = 8;
  localparam int AxSizeWidth  = 3;
  localparam int AxBurstWidth = 2;

  localparam int RowBufLenW = 10;
  localparam int RowIdWidth = AxAddrWidth - RowBufLenW;

  localparam int NumRSlots      = 3;
  localparam int RDataBankAddrW = 4;

  localparam int RowHitCost     = 10;
  localparam int PrechargeCost  = 50;
  localparam int ActivationCost = 45;
  localparam int MaxBurstEffLen = 4;
  localparam int MaxBurstCost   =
    PrechargeCost + ActivationCost + RowHitCost * MaxBurstEffLen;

  localparam int RDelayCntW = 8;

  typedef struct packed {
    logic [AxIdWidth-1:0]    id;
    logic [AxAddrWidth-1:0]  addr;
    logic [AxLenWidth-1:0]   burst_len;
    logic [AxSizeWidth-1:0]  burst_size;
    logic [AxBurstWidth-1:0] burst_type;
  } raddr_t;

  typedef struct packed {
    logic                      busy;
    logic [RDataBankAddrW-1:0] iid;
    logic [RDelayCntW-1:0]     counter;
  } rdelay_slot_t;

  function automatic logic [RowIdWidth-1:0] get_row_id(
    logic [AxAddrWidth-1:0] addr
  );
    return RowIdWidth'(addr >> RowBufLenW);
  endfunction

  function automatic logic [RDelayCntW-1:0] get_burst_cost(
    logic                  row_hit,
    logic                  row_open,
    logic [AxLenWidth-1:0] burst_len
  );
    int unsigned eff_len;
    int unsigned cost;
    eff_len = 32'(burst_len) + 1;
    if (eff_len > MaxBurstEffLen) eff_len = MaxBurstEffLen;
    cost = RowHitCost * eff_len;
    if (!row_open) cost = cost + ActivationCost;
    else if (!row_hit) cost = cost + PrechargeCost + ActivationCost;
    return RDelayCntW'(cost);
  endfunction

endpackage

// File: rtl/simmem_prio_pick.sv
// Lowest-index-first picker: one-hot grant, found flag and binary index.
module simmem_prio_pick #(
  parameter int N    = 3,
  parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    onehot_o,
  output logic            found_o,
  output logic [IdxW-1:0] idx_o
);

  always_comb begin
    onehot_o = '0;
    found_o  = 1'b0;
    idx_o    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        found_o     = 1'b1;
        idx_o       = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/simmem_rdelay_slots.sv
// Read-path delay stage: holds outstanding bursts, charges a row-buffer
// aware service cost, and releases each burst's iid once it has elapsed.
module simmem_rdelay_slots
  import simmem_pkg::*;
#(
  parameter int NumSlots = NumRSlots,
  parameter int CntW     = RDelayCntW
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [$bits(raddr_t)-1:0]  raddr_i,
  input  logic [RDataBankAddrW-1:0]  iid_i,
  input  logic                       raddr_valid_i,
  output logic                       raddr_ready_o,
  output logic                       release_valid_o,
  output logic [RDataBankAddrW-1:0]  release_iid_o,
  input  logic                       release_ready_i
);

  localparam int IdxW = (NumSlots > 1) ? $clog2(NumSlots) : 1;

  if (CntW != RDelayCntW || MaxBurstCost >= (1 << CntW)) begin : g_cnt_chk
    $error("delay counter cannot hold the maximum burst cost");
  end

  raddr_t raddr;
  assign raddr = raddr_t'(raddr_i);

  rdelay_slot_t [NumSlots-1:0] slot_q, slot_d;
  logic [RowIdWidth-1:0] open_row_q, open_row_d;
  logic                  open_row_valid_q, open_row_valid_d;
  logic                  ready_q, ready_d;

  logic [NumSlots-1:0] free, expired, busy_d;
  logic [NumSlots-1:0] alloc_oh, rel_oh;
  logic                alloc_found, rel_found;
  logic [IdxW-1:0]     alloc_idx, rel_idx;

  logic [RowIdWidth-1:0] row_id;
  logic                  row_hit;
  logic [RDelayCntW-1:0] cost;
  logic                  accept, rel_hs;

  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      free[i]    = ~slot_q[i].busy;
      expired[i] = slot_q[i].busy && (slot_q[i].counter == '0);
    end
  end

  simmem_prio_pick #(.N(NumSlots), .IdxW(IdxW)) u_alloc (
    .req_i    (free),
    .onehot_o (alloc_oh),
    .found_o  (alloc_found),
    .idx_o    (alloc_idx)
  );

  simmem_prio_pick #(.N(NumSlots), .IdxW(IdxW)) u_release (
    .req_i    (expired),
    .onehot_o (rel_oh),
    .found_o  (rel_found),
    .idx_o    (rel_idx)
  );

  assign row_id  = get_row_id(raddr.addr);
  assign row_hit = open_row_valid_q && (open_row_q == row_id);
  assign cost    = get_burst_cost(row_hit, open_row_valid_q, raddr.burst_len);

  assign raddr_ready_o   = ready_q;
  assign release_valid_o = rel_found;
  assign release_iid_o   = rel_found ? slot_q[rel_idx].iid : '0;

  assign accept = raddr_valid_i && ready_q && alloc_found;
  assign rel_hs = rel_found && release_ready_i;

  always_comb begin
    slot_d           = slot_q;
    open_row_d       = open_row_q;
    open_row_valid_d = open_row_valid_q;
    for (int i = 0; i < NumSlots; i++) begin
      if (slot_q[i].busy && slot_q[i].counter != '0) begin
        slot_d[i].counter = slot_q[i].counter - 1'b1;
      end
      if (rel_hs && rel_oh[i]) slot_d[i].busy = 1'b0;
      if (accept && alloc_oh[i]) begin
        slot_d[i].busy    = 1'b1;
        slot_d[i].iid     = iid_i;
        slot_d[i].counter = cost - 1'b1;
      end
    end
    if (accept) begin
      open_row_d       = row_id;
      open_row_valid_d = 1'b1;
    end
  end

  // Ready is registered so a slot freed this cycle only shows up next cycle.
  always_comb begin
    for (int i = 0; i < NumSlots; i++) busy_d[i] = slot_d[i].busy;
    ready_d = |(~busy_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q           <= '0;
      open_row_q       <= '0;
      open_row_valid_q <= 1'b0;
      ready_q          <= 1'b0;
    end else begin
      slot_q           <= slot_d;
      open_row_q       <= open_row_d;
      open_row_valid_q <= open_row_valid_d;
      ready_q          <= ready_d;
    end
  end

  logic unused_fields;
  assign unused_fields = ^{raddr.id, raddr.burst_size, raddr.burst_type,
                           alloc_idx};

endmodule

// File: tb/tb_simmem_rdelay_slots.sv
// Directed scoreboard bench for the read-path delay stage.
module tb_simmem_rdelay_slots;
  import simmem_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  raddr_t                    req;
  logic [RDataBankAddrW-1:0] iid = '0;
  logic                      valid = 1'b0;
  logic                      ready;
  logic                      rel_valid;
  logic [RDataBankAddrW-1:0] rel_iid;
  logic                      rel_ready = 1'b0;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  logic [RDataBankAddrW-1:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  simmem_rdelay_slots dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .raddr_i         (req),
    .iid_i           (iid),
    .raddr_valid_i   (valid),
    .raddr_ready_o   (ready),
    .release_valid_o (rel_valid),
    .release_iid_o   (rel_iid),
    .release_ready_i (rel_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [AxAddrWidth-1:0] addr,
                        input logic [7:0] len,
                        input logic [RDataBankAddrW-1:0] id,
                        output int acc);
    int g = 0;
    req           = '0;
    req.addr      = addr;
    req.burst_len = len;
    req.id        = 4'hA;
    iid           = id;
    valid         = 1'b1;
    while (!ready && g < 200) begin
      tick();
      g++;
    end
    if (g >= 200) check("accept_timeout", 32'(ready), 1);
    tick();
    valid = 1'b0;
    acc   = cyc;
    sb.push_back(id);
  endtask

  task automatic wait_valid(input string tag, input int acc,
                            input int cost);
    int g = 0;
    while (!rel_valid && g < 300) begin
      tick();
      g++;
    end
    if (g >= 300) check({tag, "_timeout"}, 32'(rel_valid), 1);
    else check({tag, "_latency"}, 32'(cyc - acc + 1), 32'(cost));
  endtask

  task automatic release_one(input string tag);
    logic [RDataBankAddrW-1:0] e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_iid"}, 32'(rel_iid), 32'(e));
    end
    rel_ready = 1'b1;
    tick();
    rel_ready = 1'b0;
  endtask

  initial begin
    int a, b, seen;
    req = '0;

    // Reset
    tick();
    check("rst_ready", 32'(ready), 0);
    check("rst_rel_valid", 32'(rel_valid), 0);
    check("rst_rel_iid", 32'(rel_iid), 0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(ready), 1);

    // 1: no open row
    accept(20'h00400, 8'd0, 4'd5, a);
    wait_valid("t1", a, 55);
    release_one("t1");

    // 2: row hit then row miss
    accept(20'h00500, 8'd3, 4'd6, a);
    wait_valid("t2_hit", a, 40);
    release_one("t2_hit");
    accept(20'h00C00, 8'd0, 4'd9, a);
    wait_valid("t2_miss", a, 105);
    release_one("t2_miss");

    // 3: effective length saturates
    accept(20'h00C40, 8'd7, 4'd2, a);
    wait_valid("t3_sat", a, 40);
    release_one("t3_sat");

    // 4: fill all slots, release in slot order
    accept(20'h00C00, 8'd0, 4'd1, a);
    accept(20'h00C00, 8'd0, 4'd2, a);
    accept(20'h00C00, 8'd0, 4'd3, a);
    check("t4_full_ready", 32'(ready), 0);
    repeat (15) tick();
    check("t4_valid", 32'(rel_valid), 1);
    check("t4_ready_before", 32'(ready), 0);
    release_one("t4_r0");
    check("t4_ready_after", 32'(ready), 1);
    release_one("t4_r1");
    release_one("t4_r2");
    check("t4_drained", 32'(rel_valid), 0);

    // 5: two slots expire together, ready toggles
    accept(20'h00C00, 8'd3, 4'd7, a);
    repeat (9) tick();
    accept(20'h00C00, 8'd2, 4'd8, b);
    wait_valid("t5", a, 40);
    check("t5_hold0", 32'(rel_iid), 7);
    tick();
    check("t5_hold1", 32'(rel_iid), 7);
    release_one("t5_r0");
    check("t5_valid_mid", 32'(rel_valid), 1);
    tick();
    check("t5_hold2", 32'(rel_iid), 8);
    release_one("t5_r1");
    check("t5_drained", 32'(rel_valid), 0);
    check("t5_sb_empty", 32'(sb.size()), 0);

    // 6: reset drops pending bursts and closes the open row
    accept(20'h00C00, 8'd0, 4'd10, a);
    accept(20'h00C00, 8'd0, 4'd11, a);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("t6_rst_ready", 32'(ready), 0);
    tick();
    rst = 1'b0;
    sb.delete();
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rel_valid) seen++;
    end
    check("t6_no_release", 32'(seen), 0);
    accept(20'h00C00, 8'd0, 4'd12, a);
    wait_valid("t6_cold", a, 55);
    release_one("t6_cold");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
